// File: rtl/buscaminas_pkg.sv
// Shared Buscaminas types and board defaults.
package buscaminas_pkg;

  localparam int unsigned DEFAULT_BOARD_W   = 8;
  localparam int unsigned DEFAULT_BOARD_H   = 8;
  localparam int unsigned DEFAULT_MAX_FLAGS = 10;

  typedef enum logic [1:0] {IDLE, CHECK, APPLY, HOLD} flag_state_t;

  // Row-major cell index; board width defaults to the standard board.
  function automatic int unsigned cell_idx(input logic [3:0] x, input logic [3:0] y,
                                           input int unsigned w = DEFAULT_BOARD_W);
    return 32'(y) * w + 32'(x);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-stage synchronizer for a slow switch, plus a registered one-cycle rising-edge pulse.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise
);

  logic meta_q, sync_q, rise_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      // Pulse lines up with the cycle in which sync_q first reads 1.
      rise_q <= meta_q & ~sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = rise_q;

endmodule

// File: rtl/flag_board.sv
// Authoritative flag map and flag count for the Buscaminas board, one toggle per switch press.
// Define FLAG_AUTOCLEAR_EN to drop flags automatically from cells once they are revealed.
module flag_board
  import buscaminas_pkg::*;
#(
  parameter int unsigned BOARD_W   = DEFAULT_BOARD_W,
  parameter int unsigned BOARD_H   = DEFAULT_BOARD_H,
  parameter int unsigned MAX_FLAGS = DEFAULT_MAX_FLAGS
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [3:0]                       casilla_x,
  input  logic [3:0]                       casilla_y,
  input  logic                             flag_req,
  input  logic                             clear_all,
  input  logic [BOARD_W*BOARD_H-1:0]       revealed,
  input  logic [3:0]                       rd_x,
  input  logic [3:0]                       rd_y,
  output logic                             rd_flag,
  output logic [BOARD_W*BOARD_H-1:0]       flags,
  output logic [$clog2(MAX_FLAGS+1)-1:0]   flag_count,
  output logic                             done,
  output logic                             reject
);

  localparam int unsigned NCELLS = BOARD_W * BOARD_H;
  localparam int unsigned IDX_W  = (NCELLS > 1) ? $clog2(NCELLS) : 1;
  localparam int unsigned CNT_W  = $clog2(MAX_FLAGS + 1);

  flag_state_t       state_q, state_d;
  logic [3:0]        cx_q, cx_d, cy_q, cy_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              bad_q, bad_d;
  logic [NCELLS-1:0] flags_q, flags_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              done_q, done_d, reject_q, reject_d;

  logic              req_level, req_rise;
  logic              chk_in_range, rd_in_range;
  logic [IDX_W-1:0]  chk_idx, rd_idx;
`ifdef FLAG_AUTOCLEAR_EN
  logic [NCELLS-1:0] ac_mask;
`endif

  sync_edge u_req_sync (
    .clk   (clk),
    .reset (reset),
    .din   (flag_req),
    .level (req_level),
    .rise  (req_rise)
  );

  assign chk_in_range = (32'(cx_q) < BOARD_W) && (32'(cy_q) < BOARD_H);
  assign chk_idx      = IDX_W'(cell_idx(cx_q, cy_q, BOARD_W));
  assign rd_in_range  = (32'(rd_x) < BOARD_W) && (32'(rd_y) < BOARD_H);
  assign rd_idx       = IDX_W'(cell_idx(rd_x, rd_y, BOARD_W));

  always_comb begin
    state_d  = state_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    idx_d    = idx_q;
    bad_d    = bad_q;
    flags_d  = flags_q;
    count_d  = count_q;
    done_d   = 1'b0;
    reject_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_rise) begin
          cx_d    = casilla_x;
          cy_d    = casilla_y;
          state_d = CHECK;
        end
      end
      CHECK: begin
        idx_d   = chk_idx;
        bad_d   = !chk_in_range || revealed[chk_idx];
        state_d = APPLY;
      end
      APPLY: begin
        if (bad_q) begin
          reject_d = 1'b1;
        end else if (flags_q[idx_q]) begin
          flags_d[idx_q] = 1'b0;
          count_d        = count_q - CNT_W'(1);
          done_d         = 1'b1;
        end else if (count_q < CNT_W'(MAX_FLAGS)) begin
          flags_d[idx_q] = 1'b1;
          count_d        = count_q + CNT_W'(1);
          done_d         = 1'b1;
        end else begin
          reject_d = 1'b1;
        end
        state_d = HOLD;
      end
      HOLD: begin
        if (!req_level) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef FLAG_AUTOCLEAR_EN
    // Applied after the toggle so a cell is never counted out twice in one cycle.
    ac_mask = flags_d & revealed;
    flags_d = flags_d & ~revealed;
    count_d = count_d - CNT_W'($countones(ac_mask));
`endif

    if (clear_all) begin
      flags_d  = '0;
      count_d  = '0;
      state_d  = IDLE;
      done_d   = 1'b0;
      reject_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cx_q     <= '0;
      cy_q     <= '0;
      idx_q    <= '0;
      bad_q    <= 1'b0;
      flags_q  <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      idx_q    <= idx_d;
      bad_q    <= bad_d;
      flags_q  <= flags_d;
      count_q  <= count_d;
      done_q   <= done_d;
      reject_q <= reject_d;
    end
  end

  assign rd_flag    = !reset && rd_in_range && flags_q[rd_idx];
  assign flags      = flags_q;
  assign flag_count = count_q;
  assign done       = done_q;
  assign reject     = reject_q;

endmodule

// File: tb/tb_flag_board.sv
// Scoreboard bench for flag_board: each press pushes its expected outcome, the pulse monitor pops it.
module tb_flag_board;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  casilla_x, casilla_y, rd_x, rd_y;
  logic        flag_req, clear_all;
  logic [63:0] revealed;
  logic        rd_flag;
  logic [63:0] flags;
  logic [3:0]  flag_count;
  logic        done, reject;

  flag_board dut (
    .clk        (clk),
    .reset      (reset),
    .casilla_x  (casilla_x),
    .casilla_y  (casilla_y),
    .flag_req   (flag_req),
    .clear_all  (clear_all),
    .revealed   (revealed),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_flag    (rd_flag),
    .flags      (flags),
    .flag_count (flag_count),
    .done       (done),
    .reject     (reject)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        done;
    logic        reject;
    logic [63:0] flags;
    int          count;
    int          issue;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [63:0] model_flags = '0;
  int          model_count = 0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && (done || reject)) begin
      if (sb.size() == 0) begin
        check("spurious_pulse", {62'd0, done, reject}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("done", 64'(done), 64'(mon_e.done));
        check("reject", 64'(reject), 64'(mon_e.reject));
        check("flags", flags, mon_e.flags);
        check("count", 64'(flag_count), 64'(mon_e.count));
        check("latency", 64'(cyc - mon_e.issue), 64'd5);
      end
    end
  end

  task automatic press(input int x, input int y, input int hold);
    exp_t e;
    int   idx;
    bit   bad;
    @(negedge clk);
    casilla_x = 4'(x);
    casilla_y = 4'(y);
    flag_req  = 1'b1;
    idx = y * 8 + x;
    bad = (x >= 8) || (y >= 8) || revealed[idx[5:0]];
    e.done = 1'b0;
    e.reject = 1'b0;
    e.issue = cyc;
    if (bad) e.reject = 1'b1;
    else if (model_flags[idx]) begin
      model_flags[idx] = 1'b0;
      model_count--;
      e.done = 1'b1;
    end else if (model_count < 10) begin
      model_flags[idx] = 1'b1;
      model_count++;
      e.done = 1'b1;
    end else e.reject = 1'b1;
    e.flags = model_flags;
    e.count = model_count;
    sb.push_back(e);
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      check("timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    repeat (hold) @(negedge clk);
    flag_req = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear_all = 1'b1;
    @(negedge clk);
    clear_all = 1'b0;
    model_flags = '0;
    model_count = 0;
    check("clear_flags", flags, 64'd0);
    check("clear_count", 64'(flag_count), 64'd0);
  endtask

  task automatic rd_check(input int x, input int y, input logic exp, input string tag);
    rd_x = 4'(x);
    rd_y = 4'(y);
    #1;
    check(tag, 64'(rd_flag), 64'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    casilla_x = '0; casilla_y = '0; flag_req = 1'b0; clear_all = 1'b0;
    revealed = '0; rd_x = 4'd2; rd_y = 4'd3;
    repeat (3) @(negedge clk);
    check("rst_flags", flags, 64'd0);
    check("rst_count", 64'(flag_count), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_reject", 64'(reject), 64'd0);
    check("rst_rd_flag", 64'(rd_flag), 64'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Set then clear one cell.
    press(2, 3, 1);
    rd_check(2, 3, 1'b1, "rd_set");
    rd_check(9, 0, 1'b0, "rd_out_of_range");
    press(2, 3, 1);
    rd_check(2, 3, 1'b0, "rd_cleared");

    // Fill to the limit, then one more is refused.
    for (int i = 0; i < 10; i++) press(i % 8, i / 8, 1);
    press(7, 7, 1);
    check("limit_bit63", 64'(flags[63]), 64'd0);

    do_clear();
    revealed[9] = 1'b1;
    press(1, 1, 1);
    press(9, 0, 1);
    press(0, 9, 1);

    // Held switch yields exactly one toggle; extra pulses show as spurious.
    press(5, 5, 50);

    // clear_all during APPLY wins and silences the pulse.
    do_clear();
    for (int i = 0; i < 4; i++) press(i, 0, 1);
    check("pre_clear_count", 64'(flag_count), 64'd4);
    @(negedge clk);
    casilla_x = 4'd6; casilla_y = 4'd6; flag_req = 1'b1;
    repeat (4) @(negedge clk);
    clear_all = 1'b1;
    @(negedge clk);
    clear_all = 1'b0;
    check("apply_clear_flags", flags, 64'd0);
    check("apply_clear_count", 64'(flag_count), 64'd0);
    check("apply_clear_pulse", {62'd0, done, reject}, 64'd0);
    model_flags = '0;
    model_count = 0;
    flag_req = 1'b0;
    repeat (6) @(negedge clk);
    check("apply_clear_after", 64'(flag_count), 64'd0);

    // Revealing a flagged cell.
    press(4, 4, 1);
    @(negedge clk);
    revealed[36] = 1'b1;
    @(negedge clk);
`ifdef FLAG_AUTOCLEAR_EN
    model_flags[36] = 1'b0;
    model_count = 0;
    check("autoclear_bit", 64'(flags[36]), 64'd0);
    check("autoclear_count", 64'(flag_count), 64'd0);
`else
    check("persist_bit", 64'(flags[36]), 64'd1);
    check("persist_count", 64'(flag_count), 64'd1);
    press(4, 4, 1);
`endif

    // Reset in the middle of a request discards it.
    press(0, 0, 1);
    @(negedge clk);
    casilla_x = 4'd1; casilla_y = 4'd0; flag_req = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    flag_req = 1'b0;
    rd_x = 4'd0; rd_y = 4'd0;
    #1;
    check("midrst_rd_flag", 64'(rd_flag), 64'd0);
    @(negedge clk);
    check("midrst_flags", flags, 64'd0);
    reset = 1'b0;
    model_flags = '0;
    model_count = 0;
    repeat (10) @(negedge clk);
    check("midrst_count", 64'(flag_count), 64'd0);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
